// File: rtl/cursor_stamp.sv
// Paints a SIZE x SIZE solid square of one colour into the frame buffer write
// port, one pixel per clock in row-major order, clipping pixels off the canvas.
module cursor_stamp #(
  parameter int SIZE  = 16,
  parameter int W_RES = 640,
  parameter int H_RES = 480
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic [7:0]  col_r,
  input  logic [7:0]  col_g,
  input  logic [7:0]  col_b,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  output logic [10:0] wr_x,
  output logic [10:0] wr_y,
  output logic [7:0]  wr_r,
  output logic [7:0]  wr_g,
  output logic [7:0]  wr_b
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cx, cy;
  logic [CW-1:0] nx, ny;
  logic [10:0]   px, py;
  logic [11:0]   sx, sy;
  logic          last_px;

  function automatic logic [11:0] add12(input logic [10:0] p, input logic [CW-1:0] c);
    return {1'b0, p} + 12'(c);
  endfunction

  function automatic logic on_canvas(input logic [11:0] x, input logic [11:0] y);
    return (x < 12'(W_RES)) && (y < 12'(H_RES));
  endfunction

  // Next raster position; the registered outputs always show the pixel (cx,cy).
  always_comb begin
    last_px = (cx == LAST) && (cy == LAST);
    nx      = (cx == LAST) ? '0 : cx + 1'b1;
    ny      = (cx == LAST) ? cy + 1'b1 : cy;
    sx      = add12(px, nx);
    sy      = add12(py, ny);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cx    <= '0;
      cy    <= '0;
      px    <= '0;
      py    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wr_en <= 1'b0;
      wr_x  <= '0;
      wr_y  <= '0;
      wr_r  <= '0;
      wr_g  <= '0;
      wr_b  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= PAINT;
            busy  <= 1'b1;
            cx    <= '0;
            cy    <= '0;
            px    <= pos_x;
            py    <= pos_y;
            // wr_r/g/b double as the colour latch: they only change here.
            wr_r  <= col_r;
            wr_g  <= col_g;
            wr_b  <= col_b;
            wr_x  <= pos_x;
            wr_y  <= pos_y;
            wr_en <= on_canvas({1'b0, pos_x}, {1'b0, pos_y});
          end
        end
        PAINT: begin
          if (last_px) begin
            state <= DONE;
            wr_en <= 1'b0;
            done  <= 1'b1;
          end else begin
            cx    <= nx;
            cy    <= ny;
            wr_x  <= sx[10:0];
            wr_y  <= sy[10:0];
            wr_en <= on_canvas(sx, sy);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_stamp.sv
// Randomized and directed bench for cursor_stamp against a cycle-indexed
// behavioural model plus a per-stamp pixel scoreboard.
module tb_cursor_stamp;

  localparam int S  = 16;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int SS = S * S;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] pos_x = '0, pos_y = '0;
  logic [7:0]  col_r = '0, col_g = '0, col_b = '0;
  logic        busy, done, wr_en;
  logic [10:0] wr_x, wr_y;
  logic [7:0]  wr_r, wr_g, wr_b;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  cursor_stamp #(.SIZE(S), .W_RES(W), .H_RES(H)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .pos_x(pos_x), .pos_y(pos_y), .col_r(col_r), .col_g(col_g), .col_b(col_b),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int count_in(input int x0, input int y0);
    int n = 0;
    for (int j = 0; j < S; j++)
      for (int i = 0; i < S; i++)
        if ((x0 + i) < W && (y0 + j) < H) n++;
    return n;
  endfunction

  // Model state: m_k is the cycle index since the accept edge (0 = idle).
  int       m_k = 0;
  int       m_px = 0, m_py = 0, m_cnt = 0;
  bit       m_run = 1'b0;
  bit [7:0] m_r = '0, m_g = '0, m_b = '0;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_k <= 0; m_px <= 0; m_py <= 0; m_run <= 1'b0;
      m_r <= '0; m_g <= '0; m_b <= '0; m_cnt <= 0;
    end else if (m_k == 0) begin
      if (start) begin
        m_k <= 1; m_px <= int'(pos_x); m_py <= int'(pos_y); m_run <= 1'b1;
        m_r <= col_r; m_g <= col_g; m_b <= col_b;
        m_cnt <= count_in(int'(pos_x), int'(pos_y));
      end
    end else if (m_k == SS + 1) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Compare process plus scoreboard of written pixels for the current stamp.
  bit seen[int];
  initial begin
    int idx, ex, ey;
    bit painting, een;
    forever begin
      @(negedge CLOCK_50);
      if (cmp_on) begin
        painting = (m_k >= 1) && (m_k <= SS);
        idx = painting ? m_k - 1 : (m_run ? SS - 1 : -1);
        ex = (idx < 0) ? 0 : m_px + idx % S;
        ey = (idx < 0) ? 0 : m_py + idx / S;
        een = painting && ex < W && ey < H;
        check("busy", busy, m_k != 0);
        check("done", done, m_k == SS + 1);
        check("wr_en", wr_en, een);
        check("wr_x", wr_x, ex & 'h7FF);
        check("wr_y", wr_y, ey & 'h7FF);
        check("wr_rgb", {wr_r, wr_g, wr_b}, {m_r, m_g, m_b});
        if (m_k == 1) seen.delete();
        if (wr_en === 1'b1) begin
          check("dup_pixel", seen.exists(int'(wr_y) * 4096 + int'(wr_x)), 0);
          seen[int'(wr_y) * 4096 + int'(wr_x)] = 1'b1;
        end
        if (m_k == SS + 1) check("pix_count", seen.num(), m_cnt);
      end
    end
  end

  task automatic go(input int x, input int y, input int r, input int g, input int b);
    @(negedge CLOCK_50);
    pos_x = 11'(x); pos_y = 11'(y);
    col_r = 8'(r); col_g = 8'(g); col_b = 8'(b);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int wc;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    cmp_on = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("rst_busy", busy, 0);
    check("rst_outs", {done, wr_en, wr_x, wr_y, wr_r, wr_g, wr_b}, 0);

    // Basic stamp with literal pins on first/17th/last write and done timing.
    go(100, 200, 255, 0, 0);
    wc = 0;
    for (int c = 1; c <= 258; c++) begin
      if (c > 1) @(negedge CLOCK_50);
      if (wr_en === 1'b1) wc++;
      if (c == 1)   check("first_xy", {wr_en, wr_x, wr_y}, {1'b1, 11'd100, 11'd200});
      if (c == 1)   check("first_rgb", {wr_r, wr_g, wr_b}, 24'hFF0000);
      if (c == 17)  check("w17_xy", {wr_x, wr_y}, {11'd100, 11'd201});
      if (c == 256) check("last_xy", {wr_en, wr_x, wr_y}, {1'b1, 11'd115, 11'd215});
      if (c == 257) check("done_257", {done, busy, wr_en}, 3'b110);
      if (c == 258) check("busy_258", {done, busy}, 2'b00);
    end
    check("writes_full", wc, 256);

    // Bottom-right corner: only 8x8 pixels land on the canvas.
    go(632, 472, 1, 2, 3);
    wc = 0;
    for (int c = 1; c <= 258; c++) begin
      if (c > 1) @(negedge CLOCK_50);
      if (wr_en === 1'b1) begin
        wc++;
        check("clip_range", (wr_x >= 632 && wr_x <= 639 && wr_y >= 472 && wr_y <= 479), 1);
      end
      if (c == 257) check("clip_done", done, 1);
    end
    check("writes_clip", wc, 64);

    // Input changes and start pulses mid-stamp and on the done cycle.
    go(10, 20, 7, 8, 9);
    for (int c = 1; c <= 259; c++) begin
      if (c > 1) @(negedge CLOCK_50);
      if (c == 5)   begin pos_x = 11'd300; col_r = 8'd99; start = 1'b1; end
      if (c == 6)   start = 1'b0;
      if (c == 257) start = 1'b1;
      if (c == 258) begin check("no_requeue", busy, 0); start = 1'b0; end
      if (c == 259) check("still_idle", busy, 0);
    end
    go(20, 30, 4, 5, 6);
    check("restart_ok", {busy, wr_x, wr_y}, {1'b1, 11'd20, 11'd30});
    wait_idle();

    // Reset while writing pixel #50.
    go(50, 60, 11, 22, 33);
    repeat (49) @(negedge CLOCK_50);
    check("w50_en", wr_en, 1);
    #1 reset = 1'b1;
    #1 check("async_rst", {busy, wr_en, done}, 0);
    repeat (3) begin
      @(negedge CLOCK_50);
      check("rst_hold", {busy, wr_en}, 0);
    end
    reset = 1'b0;
    go(0, 0, 200, 100, 50);
    check("post_rst", {wr_en, wr_x, wr_y}, {1'b1, 11'd0, 11'd0});
    wait_idle();

    // Randomized stamps with random start chatter during the stamp.
    for (int t = 0; t < 15; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      go($urandom_range(0, 700), $urandom_range(0, 520),
         $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      for (int n = 0; n < 400 && busy === 1'b1; n++) begin
        start = 1'($urandom_range(0, 1));
        pos_x = 11'($urandom_range(0, 2047));
        col_g = 8'($urandom_range(0, 255));
        @(negedge CLOCK_50);
      end
      start = 1'b0;
      check("rand_idle", busy, 0);
    end

    repeat (3) @(negedge CLOCK_50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
